// File: rtl/pr_pkg.sv
// Shared fixed-point helpers and types for the PageRank engine.
package pr_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  // Run/hold phase, derived from the iteration counter.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pr_state_e;

  // Largest representable Q0.width value (2**width - 1).
  function automatic logic [63:0] max_val(input int unsigned width);
    return (64'(1) << width) - 64'(1);
  endfunction

  // Unsigned add clamped to 2**width - 1.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [63:0] s;
    s = a + b;
    if (s > max_val(width)) s = max_val(width);
    return s;
  endfunction

  // Uniform starting rank (2**width)/n, truncated and clamped.
  function automatic logic [63:0] init_rank(input int unsigned n,
                                            input int unsigned width);
    logic [63:0] v;
    v = (64'(1) << width) / 64'(n);
    if (v > max_val(width)) v = max_val(width);
    return v;
  endfunction

endpackage

// File: rtl/pr_node_update.sv
// Next-rank computation for one destination node: sum of linked contributions, saturated.
module pr_node_update
  import pr_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [N-1:0]       adj_row,
  input  logic [N*WIDTH-1:0] contrib,
  input  logic [WIDTH-1:0]   rank,
  input  logic               en,
  output logic [WIDTH-1:0]   nxt_rank_c
);

  localparam int unsigned SW = WIDTH + $clog2(N);

  logic [SW-1:0] sum_c;

  // Accumulate in-link contributions wide, then clamp; hold the rank when not enabled.
  always_comb begin
    sum_c = '0;
    for (int j = 0; j < int'(N); j++) begin
      if (adj_row[j]) sum_c = sum_c + SW'(contrib[j*WIDTH +: WIDTH]);
    end
    nxt_rank_c = en ? WIDTH'(sat_add(64'(sum_c), 64'(0), WIDTH)) : rank;
  end

endmodule

// File: rtl/page_rank.sv
// Fixed-point PageRank power iteration: one Jacobi iteration per clock for ITER clocks.
module page_rank
  import pr_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ITER  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*N-1:0]     adj,
  input  logic [N*WIDTH-1:0] nodeWeight,
  output logic [N*WIDTH-1:0] rank,
  output logic               done
);

  localparam int unsigned CW = $clog2(ITER + 1);
  localparam logic [WIDTH-1:0] INIT = WIDTH'(init_rank(N, WIDTH));

  logic [N*N-1:0]     adj_q, adj_d;
  logic [N*WIDTH-1:0] w_q, w_d;
  logic [N*WIDTH-1:0] rank_q, rank_d;
  logic [CW-1:0]      iter_cnt_q, iter_cnt_d;
  logic               done_q, done_d;

  logic [N*WIDTH-1:0] contrib_c;
  logic [N*WIDTH-1:0] upd_c;
  pr_state_e          state_c;

  assign state_c = (iter_cnt_q == CW'(ITER)) ? ST_HOLD : ST_RUN;

  // Per-source contribution rank[j]*w[j], truncated to the upper WIDTH bits.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    contrib_c = '0;
    for (int j = 0; j < int'(N); j++) begin
      prod = (2*WIDTH)'(rank_q[j*WIDTH +: WIDTH]) * (2*WIDTH)'(w_q[j*WIDTH +: WIDTH]);
      contrib_c[j*WIDTH +: WIDTH] = WIDTH'(prod >> WIDTH);
    end
  end

  for (genvar i = 0; i < int'(N); i++) begin : g_node
    pr_node_update #(
      .N     (N),
      .WIDTH (WIDTH)
    ) u_node (
      .adj_row    (adj_q[i*N +: N]),
      .contrib    (contrib_c),
      .rank       (rank_q[i*WIDTH +: WIDTH]),
      .en         (state_c == ST_RUN),
      .nxt_rank_c (upd_c[i*WIDTH +: WIDTH])
    );
  end

  // Next state: reset latches the graph and restarts; otherwise iterate until ITER, then hold.
  always_comb begin
    adj_d      = adj_q;
    w_d        = w_q;
    rank_d     = upd_c;
    iter_cnt_d = iter_cnt_q;
    done_d     = done_q;
    if (reset) begin
      adj_d      = adj;
      w_d        = nodeWeight;
      rank_d     = {N{INIT}};
      iter_cnt_d = '0;
      done_d     = 1'b0;
    end else if (state_c == ST_RUN) begin
      iter_cnt_d = iter_cnt_q + CW'(1);
      done_d     = (iter_cnt_q == CW'(ITER - 1));
    end
  end

  // State registers; reset is folded into the next-state logic, so it is synchronous.
  always_ff @(posedge clk) begin
    adj_q      <= adj_d;
    w_q        <= w_d;
    rank_q     <= rank_d;
    iter_cnt_q <= iter_cnt_d;
    done_q     <= done_d;
  end

  assign rank = rank_q;
  assign done = done_q;

endmodule

// File: tb/tb_page_rank.sv
// Directed bench for page_rank (N=4, WIDTH=16, ITER=8).
module tb_page_rank;

  logic        clk;
  logic        reset;
  logic [15:0] adj;
  logic [63:0] nodeWeight;
  logic [63:0] rank;
  logic        done;

  int vectors = 0;
  int errs    = 0;

  localparam logic [15:0] ADJ_COMMON = 16'h3B1C;
  localparam logic [63:0] W_COMMON   = 64'h8000_FFFF_8000_5555;
  localparam logic [63:0] ALL_INIT   = 64'h4000_4000_4000_4000;

  page_rank #(.N(4), .WIDTH(16), .ITER(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .adj        (adj),
    .nodeWeight (nodeWeight),
    .rank       (rank),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference iteration straight from the arithmetic definition.
  function automatic logic [63:0] model_iter(input logic [63:0] r, input logic [15:0] a,
                                             input logic [63:0] w);
    logic [63:0] res;
    logic [31:0] sum;
    logic [31:0] p;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      sum = '0;
      for (int j = 0; j < 4; j++) begin
        if (a[i*4+j]) begin
          p   = {16'b0, r[j*16 +: 16]} * {16'b0, w[j*16 +: 16]};
          sum = sum + {16'b0, p[31:16]};
        end
      end
      res[i*16 +: 16] = (sum > 32'h0000_FFFF) ? 16'hFFFF : sum[15:0];
    end
    return res;
  endfunction

  logic [63:0] exp_r;

  initial begin
    reset      = 1'b1;
    adj        = ADJ_COMMON;
    nodeWeight = W_COMMON;

    // Reset state
    tick(2);
    check("reset_rank", rank, ALL_INIT);
    check("reset_done", 64'(done), 64'(0));

    // First two iterations, common graph
    reset = 1'b0;
    tick(1);
    check("iter1_rank", rank, 64'h3555_5555_1555_5FFF);
    check("iter1_done", 64'(done), 64'(0));
    tick(1);
    check("iter2_rank", rank, 64'h2AA9_4553_1FFF_6FFE);

    // Completion on 8th edge, then hold
    tick(5);
    check("iter7_done", 64'(done), 64'(0));
    tick(1);
    check("iter8_done", 64'(done), 64'(1));
    exp_r = ALL_INIT;
    for (int k = 0; k < 8; k++) exp_r = model_iter(exp_r, ADJ_COMMON, W_COMMON);
    check("iter8_rank", rank, exp_r);
    tick(5);
    check("hold_rank", rank, exp_r);
    check("hold_done", 64'(done), 64'(1));

    // Saturation: fully connected, unit weights
    reset      = 1'b1;
    adj        = 16'hFFFF;
    nodeWeight = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(1);
    check("sat_reset_rank", rank, ALL_INIT);
    check("sat_reset_done", 64'(done), 64'(0));
    reset = 1'b0;
    tick(1);
    check("sat_iter1", rank, 64'hFFFC_FFFC_FFFC_FFFC);
    tick(1);
    check("sat_iter2", rank, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(6);
    check("sat_final", rank, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sat_done", 64'(done), 64'(1));

    // Self-loops only, one zero weight; inputs changed while running are ignored
    reset      = 1'b1;
    adj        = 16'h8421;
    nodeWeight = 64'h0000_FFFF_8000_5555;
    tick(1);
    reset      = 1'b0;
    adj        = 16'hFFFF;
    nodeWeight = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(1);
    check("selfloop_iter1", rank, 64'h0000_3FFF_2000_1555);

    // Mid-run reset with an empty graph
    reset      = 1'b1;
    adj        = ADJ_COMMON;
    nodeWeight = W_COMMON;
    tick(1);
    reset = 1'b0;
    tick(3);
    check("midrun_before", rank, model_iter(model_iter(model_iter(ALL_INIT, ADJ_COMMON, W_COMMON),
                                                       ADJ_COMMON, W_COMMON), ADJ_COMMON, W_COMMON));
    reset = 1'b1;
    adj   = 16'h0000;
    tick(1);
    check("midrun_reset_rank", rank, ALL_INIT);
    check("midrun_reset_done", 64'(done), 64'(0));
    reset = 1'b0;
    tick(1);
    check("empty_iter1", rank, 64'h0);
    tick(6);
    check("empty_iter7_done", 64'(done), 64'(0));
    tick(1);
    check("empty_iter8_done", 64'(done), 64'(1));
    check("empty_iter8_rank", rank, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
